issue_entry_queue: RTL and testbench
====================================

// Module: issue_entry_queue
// PURPOSE
// - Producer side of the decode->issue handshake (entry/valid/is_ctrl_flow out, ack in).
// - Buffers decoded scoreboard entries from the decoder in a small circular FIFO.
// - Presents the oldest entry to the downstream reordering/issue logic.
// - Also exposes the second-oldest entry as a lookahead, so downstream logic can decide swaps.
// PARAMETERS
// - DEPTH  4  number of entries; power of two, >= 2
// PORTS
// - clk_i                   in   1       clock
// - rst_i                   in   1       synchronous reset, active-high
// - flush_i                 in   1       synchronous flush of all buffered entries
// - debug_req_i             in   1       while high, no new entries are accepted
// - decoded_entry_i         in   SBE     ariane_pkg::scoreboard_entry_t from decoder
// - decoded_valid_i         in   1       decoder entry valid
// - decoded_is_ctrl_flow_i  in   1       decoder entry is control flow
// - decoded_ready_o         out  1       queue can accept an entry this cycle
// - issue_entry_o           out  SBE     oldest entry
// - issue_entry_valid_o     out  1       oldest entry valid
// - is_ctrl_flow_o          out  1       oldest entry is control flow
// - issue_instr_ack_i       in   1       downstream consumed the oldest entry
// - peek_entry_o            out  SBE     second-oldest entry
// - peek_valid_o            out  1       second-oldest entry valid (count >= 2)
// - count_o                 out  CW      occupancy; CW = $clog2(DEPTH+1)
// BEHAVIOUR
// - Reset: rd_ptr, wr_ptr and count are 0; storage is not cleared.
//   - While rst_i is high: decoded_ready_o=0, issue_entry_valid_o=0, peek_valid_o=0, count_o=0.
//   - issue_entry_o and peek_entry_o are '0 whenever their valid is 0.
// - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//   - count is tracked separately; full = (count==DEPTH), empty = (count==0).
// - decoded_ready_o = !full && !debug_req_i && !flush_i.
//   - No combinational path from issue_instr_ack_i to decoded_ready_o.
//   - A full queue does not accept a push even in a cycle that pops.
// - push = decoded_valid_i && decoded_ready_o.
//   - Writes {entry, is_ctrl_flow} at wr_ptr; wr_ptr+1; count+1.
// - pop = issue_entry_valid_o && issue_instr_ack_i.
//   - rd_ptr+1; count-1.
//   - An ack while valid_o=0 is ignored.
// - Simultaneous push and pop: both pointers advance; count unchanged.
// - Outputs: issue_* come from slot rd_ptr; peek_* come from slot rd_ptr+1 (wrapping).
//   - Purely registered-state driven, except the bypass path below.
// - Latency (no bypass): an entry pushed in cycle N is visible on issue_* in cycle N+1.
// - Ordering is strict FIFO; entries are never dropped or duplicated.
// - Flush: takes priority over push and pop in the same cycle.
//   - Next state: pointers=0, count=0; valids go low in the next cycle.
// - Reset mid-operation behaves identically to flush, and also forces ready low.
// - debug_req_i only blocks pushes; buffered entries keep draining.
// CONFIGURATION
// - Macro ISSUE_QUEUE_BYPASS_EN.
// - Defined: when the queue is empty and decoded_valid_i=1 (and !flush_i, !debug_req_i):
//   - issue_* are driven combinationally from decoded_*, with issue_entry_valid_o=1.
//   - If issue_instr_ack_i is high the same cycle, the entry is consumed and not written (count stays 0).
//   - Otherwise it is written normally and is held on issue_* next cycle.
//   - peek_valid_o stays 0 during bypass.
// - Undefined: no bypass; minimum latency is 1 cycle, and all outputs come from registers/storage.
// TESTING
// - Reset: hold rst_i=1 for 3 cycles with decoded_valid_i=1 -> ready_o=0, valid_o=0, count_o=0;
//   after release, ready_o=1.
// - Fill and drain: push A,B,C,D with ack=0 -> count_o=4, ready_o=0, issue=A, peek=B.
//   Then ack 4 cycles -> issue sequence A,B,C,D; count_o=0.
// - Wrap and simultaneous events: push/pop every cycle for 10 entries (DEPTH=4) -> count_o constant;
//   output order matches input order across pointer wrap.
// - Flush priority: count=3; in one cycle apply flush_i=1, push E, ack=1 -> next cycle count_o=0,
//   valid_o=0, and E never appears.
// - Debug hold: debug_req_i=1, decoded_valid_i=1 for 5 cycles -> ready_o=0 and no pushes;
//   2 buffered entries still drain on ack.
// - Bypass: empty queue, push X with ack=1 -> with ISSUE_QUEUE_BYPASS_EN, valid_o=1 and entry=X
//   the same cycle, count_o stays 0. Without the macro, X appears the next cycle.

Source files
------------

// File: rtl/issue_entry_queue.sv
// Circular FIFO between decoder and issue stage; exposes oldest entry plus a lookahead.
// Define ISSUE_QUEUE_BYPASS_EN to let a decoded entry pass straight through an empty queue.
module issue_entry_queue #(
    parameter int unsigned DEPTH = 4,
    parameter type         sbe_t = logic [63:0],
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          debug_req_i,
    input  sbe_t          decoded_entry_i,
    input  logic          decoded_valid_i,
    input  logic          decoded_is_ctrl_flow_i,
    output logic          decoded_ready_o,
    output sbe_t          issue_entry_o,
    output logic          issue_entry_valid_o,
    output logic          is_ctrl_flow_o,
    input  logic          issue_instr_ack_i,
    output sbe_t          peek_entry_o,
    output logic          peek_valid_o,
    output logic [CW-1:0] count_o
);

    sbe_t             mem_q [DEPTH];
    logic [DEPTH-1:0] cf_q;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    peek_ptr;

    logic empty, full;
    logic push, pop, wr_en;
    logic bypass_act, bypass_consume;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign peek_ptr = rd_ptr_q + PW'(1);

    // Ready depends only on state and control inputs, never on the ack.
    assign decoded_ready_o = !rst_i && !full && !debug_req_i && !flush_i;
    assign push            = decoded_valid_i && decoded_ready_o;

`ifdef ISSUE_QUEUE_BYPASS_EN
    assign bypass_act = !rst_i && empty && decoded_valid_i && !flush_i && !debug_req_i;
`else
    assign bypass_act = 1'b0;
`endif
    // A bypassed entry acked in the same cycle never touches storage.
    assign bypass_consume = bypass_act && issue_instr_ack_i;

    assign pop   = !rst_i && !empty && issue_instr_ack_i;
    assign wr_en = push && !bypass_consume;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rst_i || flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (!bypass_consume) begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally left uncleared on reset; valids gate its visibility.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= decoded_entry_i;
            cf_q[wr_ptr_q]  <= decoded_is_ctrl_flow_i;
        end
    end

    always_comb begin
        issue_entry_valid_o = !rst_i && (!empty || bypass_act);
        issue_entry_o       = '0;
        is_ctrl_flow_o      = 1'b0;
        if (bypass_act) begin
            issue_entry_o  = decoded_entry_i;
            is_ctrl_flow_o = decoded_is_ctrl_flow_i;
        end else if (issue_entry_valid_o) begin
            issue_entry_o  = mem_q[rd_ptr_q];
            is_ctrl_flow_o = cf_q[rd_ptr_q];
        end
    end

    always_comb begin
        peek_valid_o = !rst_i && (count_q >= CW'(2));
        peek_entry_o = '0;
        if (peek_valid_o) peek_entry_o = mem_q[peek_ptr];
    end

    assign count_o = rst_i ? '0 : count_q;

endmodule

// File: tb/tb_issue_entry_queue.sv
// Randomized and directed bench for issue_entry_queue against a queue-based reference model.
module tb_issue_entry_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, dbg, vld, cf, ack;
    logic [63:0] din;
    logic        ready, ivalid, icf, pvalid;
    logic [63:0] ientry, pentry;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] q[$];   // {is_ctrl_flow, entry}, oldest at index 0

    always #5 clk = ~clk;

    issue_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .debug_req_i           (dbg),
        .decoded_entry_i       (din),
        .decoded_valid_i       (vld),
        .decoded_is_ctrl_flow_i(cf),
        .decoded_ready_o       (ready),
        .issue_entry_o         (ientry),
        .issue_entry_valid_o   (ivalid),
        .is_ctrl_flow_o        (icf),
        .issue_instr_ack_i     (ack),
        .peek_entry_o          (pentry),
        .peek_valid_o          (pvalid),
        .count_o               (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic step();
        logic        e_ready, e_valid, e_pvalid, byp;
        logic [64:0] e_head, e_peek;
        int          sz;
        @(negedge clk);
        sz       = q.size();
        e_ready  = !rst && sz < DEPTH && !dbg && !flush;
`ifdef ISSUE_QUEUE_BYPASS_EN
        byp      = !rst && sz == 0 && vld && !flush && !dbg;
`else
        byp      = 1'b0;
`endif
        e_valid  = !rst && (sz > 0 || byp);
        e_pvalid = !rst && sz >= 2;
        e_head   = byp ? {cf, din} : (e_valid ? q[0] : 65'd0);
        e_peek   = e_pvalid ? q[1] : 65'd0;
        chk("ready", 64'(ready), 64'(e_ready));
        chk("valid", 64'(ivalid), 64'(e_valid));
        chk("entry", ientry, e_head[63:0]);
        chk("ctrl_flow", 64'(icf), 64'(e_head[64]));
        chk("peek_valid", 64'(pvalid), 64'(e_pvalid));
        chk("peek_entry", pentry, e_peek[63:0]);
        chk("count", 64'(count), rst ? 64'd0 : 64'(sz));
        if (rst || flush) begin
            q.delete();
        end else if (!(byp && ack)) begin
            if (e_valid && ack) void'(q.pop_front());
            if (vld && e_ready) q.push_back({cf, din});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic a);
        vld = v; din = d; cf = d[0]; ack = a;
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; dbg = 1'b0; vld = 1'b1; cf = 1'b0; ack = 1'b0;
        din = 64'hdead_0000_0000_0001;
        // Reset held with a valid decoder input
        repeat (3) step();
        rst = 1'b0;
        // Fill A..D, hold full, then drain
        drive(1, 64'hA, 0); drive(1, 64'hB, 0); drive(1, 64'hC, 0); drive(1, 64'hD, 0);
        drive(1, 64'hE0, 0);
        repeat (4) drive(0, 64'h0, 1);
        drive(0, 64'h0, 0);
        // Streaming push/pop across pointer wrap
        drive(1, 64'h100, 0);
        for (int i = 1; i <= 10; i++) drive(1, 64'h100 + 64'(i), 1);
        repeat (2) drive(0, 64'h0, 1);
        // Flush with simultaneous push and ack at count 3
        drive(1, 64'h201, 0); drive(1, 64'h202, 0); drive(1, 64'h203, 0);
        flush = 1'b1; drive(1, 64'hE, 1); flush = 1'b0;
        drive(0, 64'h0, 0);
        // Debug hold blocks pushes while buffered entries drain
        drive(1, 64'h301, 0); drive(1, 64'h302, 0);
        dbg = 1'b1;
        for (int i = 0; i < 5; i++) drive(1, 64'h3F0 + 64'(i), 0);
        drive(1, 64'h3FE, 1); drive(1, 64'h3FF, 1);
        dbg = 1'b0;
        drive(0, 64'h0, 0);
        // Empty queue, push with ack in the same cycle
        drive(1, 64'h5A5A, 1);
        drive(0, 64'h0, 0);
        drive(1, 64'h5A5B, 0);
        drive(0, 64'h0, 1);
        // Mid-operation reset
        drive(1, 64'h401, 0); drive(1, 64'h402, 0);
        rst = 1'b1; drive(1, 64'h403, 1); rst = 1'b0;
        drive(0, 64'h0, 0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(99) < 2);
            flush = ($urandom_range(99) < 3);
            dbg   = ($urandom_range(99) < 10);
            vld   = ($urandom_range(99) < 60);
            ack   = ($urandom_range(99) < 50);
            din   = {$urandom, $urandom};
            cf    = $urandom_range(1);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
